// File: rtl/nco_ctrl.sv
// Run/frequency controller for the carrier NCO: owns clken and phi_inc,
// applies frequency requests as a jump or a linear ramp, and qualifies lock.
module nco_ctrl #(
    parameter int unsigned     PHW         = 37,
    parameter logic [PHW-1:0]  DEFAULT_PHI = 37'd34359738368,
    parameter int unsigned     STEP_SHIFT  = 4,
    parameter int unsigned     DWELL       = 8,
    parameter int unsigned     SETTLE      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [PHW-1:0] cfg_phi_inc,
    input  logic           cfg_ramp,
    output logic           nco_clken,
    output logic [PHW-1:0] nco_phi_inc,
    input  logic           nco_out_valid,
    output logic           locked,
    output logic           busy
);

    // state    | meaning
    // S_IDLE   | NCO stopped, requests load directly
    // S_RAMP   | stepping the increment toward the target
    // S_SETTLE | waiting for SETTLE consecutive nco_out_valid cycles
    // S_LOCK   | carrier stable at the target
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RAMP   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_LOCK   = 2'd3;

    localparam int unsigned SCW  = $clog2(SETTLE + 1);
    localparam int unsigned DCW  = $clog2(DWELL);
    localparam int unsigned STCW = STEP_SHIFT + 1;

    localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [DCW-1:0]  DWELL_LAST  = DCW'(DWELL - 1);
    localparam logic [STCW-1:0] STEP_LAST   = STCW'((2 ** STEP_SHIFT) - 1);

    logic [1:0]            r_state;
    logic [PHW-1:0]        r_phi;
    logic [PHW-1:0]        r_target;
    logic signed [PHW:0]   r_step;
    logic [SCW-1:0]        r_settle_cnt;
    logic [DCW-1:0]        r_dwell_cnt;
    logic [STCW-1:0]       r_step_cnt;

    logic                  w_ready;
    logic                  w_accept;
    logic signed [PHW:0]   w_diff;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_LOCK);
    assign w_accept = cfg_valid && w_ready;
    assign w_diff   = $signed({1'b0, cfg_phi_inc}) - $signed({1'b0, r_phi});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phi        <= DEFAULT_PHI;
            r_target     <= DEFAULT_PHI;
            r_step       <= '0;
            r_settle_cnt <= '0;
            r_dwell_cnt  <= '0;
            r_step_cnt   <= '0;
        end else if (!en) begin
            // Abort: a request accepted on this edge is still captured, but never starts a ramp.
            r_state <= S_IDLE;
            if (w_accept) begin
                r_target <= cfg_phi_inc;
                if ((r_state == S_IDLE) || !cfg_ramp) begin
                    r_phi <= cfg_phi_inc;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_target <= cfg_phi_inc;
                        r_phi    <= cfg_phi_inc;
                    end
                    r_settle_cnt <= '0;
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (!nco_out_valid) begin
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= S_LOCK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_LOCK: begin
                    if (w_accept) begin
                        r_target <= cfg_phi_inc;
                        if (cfg_ramp) begin
                            r_step      <= w_diff >>> STEP_SHIFT;
                            r_dwell_cnt <= '0;
                            r_step_cnt  <= '0;
                            r_state     <= S_RAMP;
                        end else begin
                            r_phi        <= cfg_phi_inc;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end
                    end
                end
                S_RAMP: begin
                    if (r_dwell_cnt == DWELL_LAST) begin
                        r_dwell_cnt <= '0;
                        // The last update lands on the target to drop the shift truncation residue.
                        if (r_step_cnt == STEP_LAST) begin
                            r_phi        <= r_target;
                            r_step_cnt   <= '0;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_phi      <= PHW'({1'b0, r_phi} + r_step);
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cfg_ready   = w_ready;
    assign nco_clken   = (r_state != S_IDLE);
    assign locked      = (r_state == S_LOCK);
    assign busy        = (r_state == S_RAMP) || (r_state == S_SETTLE);
    assign nco_phi_inc = r_phi;

endmodule

// File: tb/tb_nco_ctrl.sv
// Self-checking bench for nco_ctrl: expected increments come from plain
// arithmetic on base/target/step rather than a copy of the state machine.
module tb_nco_ctrl;

    localparam int     PHW     = 37;
    localparam longint MASK    = (64'sd1 <<< 37) - 1;
    localparam longint DEF_PHI = 64'sd34359738368;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [PHW-1:0]  cfg_phi_inc;
    logic            cfg_ramp;
    logic            nco_clken;
    logic [PHW-1:0]  nco_phi_inc;
    logic            nco_out_valid;
    logic            locked;
    logic            busy;

    int errors = 0;
    int checks = 0;

    nco_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_phi_inc   (cfg_phi_inc),
        .cfg_ramp      (cfg_ramp),
        .nco_clken     (nco_clken),
        .nco_phi_inc   (nco_phi_inc),
        .nco_out_valid (nco_out_valid),
        .locked        (locked),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (locked !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic jump_to(input logic [PHW-1:0] x);
        int n;
        cfg_phi_inc = x;
        cfg_ramp    = 1'b0;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        wait_lock(n);
    endtask

    function automatic logic [PHW-1:0] rand37();
        logic [4:0]  hi;
        logic [31:0] lo;
        hi = 5'($urandom);
        lo = $urandom;
        return {hi, lo};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (nco_phi_inc !== 37'(DEF_PHI)) begin errors++; $display("FAIL reset_phi got=%0d exp=%0d", nco_phi_inc, DEF_PHI); end
        checks++; if (nco_clken !== 1'b0) begin errors++; $display("FAIL reset_clken got=%b exp=0", nco_clken); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        int n;
        en = 1'b1;
        tick();
        checks++; if (nco_clken !== 1'b1) begin errors++; $display("FAIL start_clken got=%b exp=1", nco_clken); end
        checks++; if (busy !== 1'b1 || locked !== 1'b0 || cfg_ready !== 1'b0) begin errors++; $display("FAIL start_flags busy=%b locked=%b ready=%b exp=1/0/0", busy, locked, cfg_ready); end
        checks++; if (nco_phi_inc !== 37'(DEF_PHI)) begin errors++; $display("FAIL start_phi got=%0d exp=%0d", nco_phi_inc, DEF_PHI); end
        wait_lock(n);
        checks++; if (n != 16) begin errors++; $display("FAIL start_lock_cycles got=%0d exp=16", n); end
    endtask

    task automatic test_jump(input logic [PHW-1:0] x);
        int n;
        int bad;
        cfg_phi_inc = x;
        cfg_ramp    = 1'b0;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        checks++; if (nco_phi_inc !== x) begin errors++; $display("FAIL jump_phi got=%0d exp=%0d", nco_phi_inc, x); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL jump_locked_fall got=%b exp=0", locked); end
        n = 0;
        bad = 0;
        while (locked !== 1'b1 && n < 400) begin
            if (cfg_ready !== 1'b0) bad++;
            tick();
            n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL jump_lock_cycles got=%0d exp=16", n); end
        checks++; if (bad != 0) begin errors++; $display("FAIL jump_ready_low got=%0d high cycles exp=0", bad); end
    endtask

    task automatic test_ramp(input logic [PHW-1:0] base, input logic [PHW-1:0] tgt);
        longint d, step, exp;
        int n, bad_phi, bad_flags;
        jump_to(base);
        checks++; if (nco_phi_inc !== base || locked !== 1'b1) begin errors++; $display("FAIL ramp_base got=%0d locked=%b exp=%0d locked=1", nco_phi_inc, locked, base); end
        d    = longint'(tgt) - longint'(base);
        step = d >>> 4;
        cfg_phi_inc = tgt;
        cfg_ramp    = 1'b1;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        checks++; if (cfg_ready !== 1'b0 || busy !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL ramp_entry ready=%b busy=%b locked=%b exp=0/1/0", cfg_ready, busy, locked); end
        bad_phi = 0;
        bad_flags = 0;
        for (int j = 1; j <= 128; j++) begin
            tick();
            n = j / 8;
            exp = (n == 16) ? longint'(tgt) : ((longint'(base) + longint'(n) * step) & MASK);
            if (nco_phi_inc !== 37'(exp)) begin
                bad_phi++;
                if (bad_phi <= 3) $display("FAIL ramp_phi cycle=%0d got=%0d exp=%0d", j, nco_phi_inc, exp);
            end
            if (busy !== 1'b1 || cfg_ready !== 1'b0 || nco_clken !== 1'b1) bad_flags++;
        end
        checks++; if (bad_phi != 0) begin errors++; $display("FAIL ramp_profile got=%0d wrong cycles exp=0", bad_phi); end
        checks++; if (bad_flags != 0) begin errors++; $display("FAIL ramp_flags got=%0d wrong cycles exp=0", bad_flags); end
        wait_lock(n);
        checks++; if (n != 16) begin errors++; $display("FAIL ramp_lock_cycles got=%0d exp=16", n); end
        checks++; if (nco_phi_inc !== tgt) begin errors++; $display("FAIL ramp_final got=%0d exp=%0d", nco_phi_inc, tgt); end
    endtask

    task automatic test_settle_glitch();
        int n;
        cfg_phi_inc = 37'd40000000000;
        cfg_ramp    = 1'b0;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        repeat (10) tick();
        nco_out_valid = 1'b0;
        tick();
        checks++; if (locked !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL glitch_state locked=%b busy=%b exp=0/1", locked, busy); end
        nco_out_valid = 1'b1;
        wait_lock(n);
        checks++; if (n != 16) begin errors++; $display("FAIL glitch_lock_cycles got=%0d exp=16", n); end
    endtask

    task automatic test_abort();
        logic [PHW-1:0] base, tgt;
        longint step, frozen;
        int n, bad;
        base = 37'd34359738368;
        tgt  = rand37();
        jump_to(base);
        step = (longint'(tgt) - longint'(base)) >>> 4;
        frozen = (longint'(base) + 5 * step) & MASK;
        cfg_phi_inc = tgt;
        cfg_ramp    = 1'b1;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        repeat (40) tick();
        checks++; if (nco_phi_inc !== 37'(frozen)) begin errors++; $display("FAIL abort_update5 got=%0d exp=%0d", nco_phi_inc, frozen); end
        en = 1'b0;
        tick();
        checks++; if (nco_clken !== 1'b0 || locked !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_flags clken=%b locked=%b busy=%b ready=%b exp=0/0/0/1", nco_clken, locked, busy, cfg_ready); end
        repeat (12) tick();
        checks++; if (nco_phi_inc !== 37'(frozen)) begin errors++; $display("FAIL abort_frozen got=%0d exp=%0d", nco_phi_inc, frozen); end
        en = 1'b1;
        tick();
        checks++; if (nco_clken !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL reenable_flags clken=%b busy=%b exp=1/1", nco_clken, busy); end
        wait_lock(n);
        checks++; if (n != 16) begin errors++; $display("FAIL reenable_lock_cycles got=%0d exp=16", n); end
        bad = 0;
        for (int j = 0; j < 150; j++) begin
            tick();
            if (nco_phi_inc !== 37'(frozen) || locked !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reenable_no_ramp got=%0d changed cycles exp=0", bad); end
    endtask

    task automatic test_en_drop_with_jump();
        logic [PHW-1:0] x, y;
        int n;
        x = rand37();
        y = rand37();
        cfg_phi_inc = x;
        cfg_ramp    = 1'b0;
        cfg_valid   = 1'b1;
        en          = 1'b0;
        tick();
        cfg_valid   = 1'b0;
        checks++; if (nco_phi_inc !== x) begin errors++; $display("FAIL drop_jump_phi got=%0d exp=%0d", nco_phi_inc, x); end
        checks++; if (nco_clken !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL drop_jump_idle clken=%b ready=%b busy=%b exp=0/1/0", nco_clken, cfg_ready, busy); end
        cfg_phi_inc = y;
        cfg_ramp    = 1'b1;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        checks++; if (nco_phi_inc !== y || nco_clken !== 1'b0) begin errors++; $display("FAIL idle_load got=%0d clken=%b exp=%0d clken=0", nco_phi_inc, nco_clken, y); end
        en = 1'b1;
        tick();
        wait_lock(n);
        checks++; if (n != 16 || nco_phi_inc !== y) begin errors++; $display("FAIL idle_load_lock cycles=%0d phi=%0d exp=16 %0d", n, nco_phi_inc, y); end
    endtask

    task automatic test_reset_mid_ramp();
        int n;
        cfg_phi_inc = 37'd100000000000;
        cfg_ramp    = 1'b1;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        checks++; if (nco_phi_inc !== 37'(DEF_PHI) || nco_clken !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midramp_reset phi=%0d clken=%b ready=%b busy=%b exp=%0d/0/1/0", nco_phi_inc, nco_clken, cfg_ready, busy, DEF_PHI); end
        rst = 1'b0;
        tick();
        wait_lock(n);
        checks++; if (n != 16 || nco_phi_inc !== 37'(DEF_PHI)) begin errors++; $display("FAIL post_reset_lock cycles=%0d phi=%0d exp=16 %0d", n, nco_phi_inc, DEF_PHI); end
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        cfg_valid     = 1'b0;
        cfg_ramp      = 1'b0;
        cfg_phi_inc   = '0;
        nco_out_valid = 1'b1;
        test_reset();
        test_startup();
        test_jump(37'd68719476736);
        test_jump(rand37());
        test_ramp(37'd34359738368, 37'd68719476736);
        test_ramp(37'd68719476736, 37'd68719476731);
        test_ramp(37'd5000, 37'd5000);
        for (int i = 0; i < 4; i++) begin
            test_ramp(rand37(), rand37());
        end
        test_settle_glitch();
        test_abort();
        test_en_drop_with_jump();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_ctrl.md
# nco_ctrl

Run/frequency controller for the carrier NCO in the QAM16 transmit path. It owns the NCO's `clken` and `phi_inc` inputs. It accepts frequency-change requests over a valid/ready handshake and applies each one either as an immediate jump or as a linear ramp. It also qualifies the NCO output with a `locked` flag that the modulator uses before it starts mixing symbols.

## Interface
Parameters:
- `PHW`, 37: phase-increment width; matches the NCO `phi_inc_i` port.
- `DEFAULT_PHI`, 37'd34359738368: increment loaded at reset (2 MHz carrier).
- `STEP_SHIFT`, 4: a ramp has 2^STEP_SHIFT increment updates.
- `DWELL`, 8: clock cycles between ramp updates (≥2).
- `SETTLE`, 16: consecutive `nco_out_valid` cycles required before `locked` asserts (≥1).

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; level-sensitive.
- `cfg_valid`  in  1  request valid.
- `cfg_ready`  out  1  request accepted when `cfg_valid && cfg_ready` is high at a rising edge.
- `cfg_phi_inc`  in  PHW  target increment, unsigned.
- `cfg_ramp`  in  1  1 = ramp to the target, 0 = jump to it.
- `nco_clken`  out  1  drives the NCO `clken`.
- `nco_phi_inc`  out  PHW  drives the NCO `phi_inc_i`; registered.
- `nco_out_valid`  in  1  the NCO `out_valid`.
- `locked`  out  1  carrier is stable at the current target.
- `busy`  out  1  high in the RAMP and SETTLE states.

## Operation
States:
- IDLE: NCO stopped.
- RAMP: stepping the increment toward the target.
- SETTLE: waiting for the NCO output to qualify.
- LOCK: carrier stable.

Reset values: state IDLE, `nco_phi_inc`=DEFAULT_PHI, target=DEFAULT_PHI, `nco_clken`=0, `locked`=0, `busy`=0, `cfg_ready`=1, all counters 0.

Outputs by state:
- `cfg_ready` = 1 only in IDLE and LOCK.
- `nco_clken` = 1 in every state except IDLE.
- `locked` = 1 only in LOCK.

IDLE:
- An accepted request loads target and `nco_phi_inc` = `cfg_phi_inc` directly. `cfg_ramp` is ignored because nothing is running.
- `en`=1 → SETTLE with the settle counter at 0.

SETTLE:
- The counter increments on each cycle with `nco_out_valid`=1.
- The counter clears to 0 on any cycle with `nco_out_valid`=0.
- When the count reaches SETTLE → LOCK.

LOCK, accepted request with `cfg_ramp`=0:
- `nco_phi_inc` = target = `cfg_phi_inc`.
- → SETTLE, counter cleared.

LOCK, accepted request with `cfg_ramp`=1:
- Computes a signed PHW+1-bit difference d = cfg_phi_inc − nco_phi_inc.
- step = d >>> STEP_SHIFT (arithmetic shift, truncation toward −inf).
- Clears the dwell and step counters, then → RAMP.

RAMP:
- The dwell counter counts 0..DWELL−1.
- At each wrap, `nco_phi_inc` is updated and the step counter increments.
- Updates 1 .. 2^STEP_SHIFT−1 add `step` (modulo 2^PHW).
- Update 2^STEP_SHIFT writes the target exactly, which removes the truncation residue.
- After the final update → SETTLE.
- A zero difference still runs the full ramp, with every update leaving the value unchanged.

Global rules:
- `en`=0 in any state → IDLE on the next edge, with `nco_clken`=0 and `locked`=0.
- On that abort, `nco_phi_inc` keeps its present value, including a mid-ramp value; target is unchanged.
- Re-enabling goes to SETTLE with the held `nco_phi_inc`. It does not resume the ramp.
- `rst` overrides everything, including mid-ramp.
- Requests arriving while `cfg_ready`=0 are held off. The requester must keep `cfg_valid` and its data stable until acceptance.

## Timing
- Handshake to `nco_phi_inc`, jump: the accept edge k updates `nco_phi_inc`, so it is visible from cycle k+1. `locked` falls at edge k.
- `cfg_ready` falls at edge k for both jump and ramp.
- Ramp: the first update lands at edge k+DWELL and the last at edge k+DWELL·2^STEP_SHIFT. RAMP lasts DWELL·2^STEP_SHIFT cycles (128 with defaults).
- `locked` rises at the edge where the SETTLE-th consecutive valid cycle is counted. That is SETTLE cycles after SETTLE entry when `nco_out_valid` is continuously high.
- `en` 0→1 raises `nco_clken` one edge later. `en` 1→0 drops `nco_clken`, `locked` and `busy` one edge later.
- If `en` falls on the same edge as a request is accepted in LOCK, the request is still captured into target / `nco_phi_inc` (jump) and the state goes to IDLE. Abort wins over RAMP entry.

## Test plan
- Reset, then `en`=1 with `nco_out_valid` tied to 1 → `nco_phi_inc`=34359738368, `nco_clken` high at edge 1, `locked` high 16 cycles after SETTLE entry.
- In LOCK, jump request with `cfg_phi_inc`=68719476736 → `nco_phi_inc`=68719476736 the next cycle, `locked` low for 16 cycles then high again, `cfg_ready` low throughout.
- In LOCK at 2^35, ramp request to 2^36 → step=2^31, `nco_phi_inc` increases by 2147483648 every 8 cycles, reaches 68719476736 at update 16 (cycle 128), `busy` high until lock.
- Downward ramp from 68719476736 to 68719476731 (d=−5, step=−1) → 15 updates of −1 reach 68719476721, and the final update writes 68719476731 exactly.
- During SETTLE, pulse `nco_out_valid` low at count 10 → the counter clears, and `locked` rises 16 cycles after valid returns.
- Drop `en` at ramp update 5 → next edge IDLE, `nco_clken`=0, `nco_phi_inc` frozen at base+5·step. Re-enable → SETTLE then LOCK at the frozen value, with no further ramp updates.
